// File: rtl/rv32i_pkg.sv
// Shared RV32I integer-core constants used by the register file and its scoreboard.
package rv32i_pkg;

    localparam int XLEN           = 32;
    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);
    localparam int BUSY_CNT_WIDTH = $clog2(REG_COUNT + 1);

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: tracks in-flight producers, gates WAW reservations
// and keeps an incrementally maintained count of busy registers.
module rf_scoreboard
    import rv32i_pkg::*;
#(
    parameter int NUM_WR         = 1,
    parameter int REG_COUNT      = rv32i_pkg::REG_COUNT,
    parameter int REG_ADDR_WIDTH = $clog2(REG_COUNT),
    parameter int CNT_WIDTH      = $clog2(REG_COUNT + 1)
) (
    input  logic                             clk,
    input  logic                             areset,
    input  logic [NUM_WR-1:0]                wr_en,
    input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic                             issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]        issue_addr,
    output logic                             issue_ready,
    output logic [REG_COUNT-1:0]             busy,
    output logic [CNT_WIDTH-1:0]             busy_count
);

    localparam logic [REG_ADDR_WIDTH:0] REG_LIMIT = REG_COUNT[REG_ADDR_WIDTH:0];

    logic [REG_COUNT-1:0] busy_reg;
    logic [REG_COUNT-1:0] busy_next;
    logic [REG_COUNT-1:0] set_vec;
    logic [REG_COUNT-1:0] clr_vec;
    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 issue_in_range;
    logic                 issue_accept;

    assign issue_in_range = ({1'b0, issue_addr} < REG_LIMIT);

    // A retiring write to the requested register frees it in the same cycle,
    // so the new reservation can take over without a bubble.
    assign issue_ready = (issue_addr == '0) || !issue_in_range ||
                         !busy_reg[issue_addr] || clr_vec[issue_addr];

    assign issue_accept = issue_valid && issue_ready && (issue_addr != '0) && issue_in_range;

    genvar gi, gj;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            logic [NUM_WR-1:0] port_hit;
            for (gj = 0; gj < NUM_WR; gj++) begin : g_port
                assign port_hit[gj] = wr_en[gj] &&
                    (wr_addr[gj*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == REG_ADDR_WIDTH'(gi));
            end
            assign clr_vec[gi]   = (gi != 0) && (|port_hit);
            assign set_vec[gi]   = (gi != 0) && issue_accept && (issue_addr == REG_ADDR_WIDTH'(gi));
            // Set beats clear: a new producer supersedes the one retiring.
            assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        for (int r = 0; r < REG_COUNT; r++) begin
            if (busy_next[r] && !busy_reg[r]) begin
                count_next = count_next + CNT_WIDTH'(1);
            end else if (!busy_next[r] && busy_reg[r]) begin
                count_next = count_next - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            busy_reg  <= '0;
            count_reg <= '0;
        end else begin
            busy_reg  <= busy_next;
            count_reg <= count_next;
        end
    end

    assign busy       = busy_reg;
    assign busy_count = count_reg;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with asynchronous reads and a busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module register_file_mp
    import rv32i_pkg::*;
#(
    parameter int NUM_RD         = 2,
    parameter int NUM_WR         = 1,
    parameter int XLEN           = rv32i_pkg::XLEN,
    parameter int REG_COUNT      = rv32i_pkg::REG_COUNT,
    parameter int REG_ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                             clk,
    input  logic                             areset,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]           rdata,
    output logic [NUM_RD-1:0]                rbusy,
    input  logic [NUM_WR-1:0]                wr_en,
    input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*XLEN-1:0]           wdata,
    input  logic                             issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]        issue_addr,
    output logic                             issue_ready,
    output logic [$clog2(REG_COUNT+1)-1:0]   busy_count
);

    localparam int CNT_WIDTH = $clog2(REG_COUNT + 1);
    localparam logic [REG_ADDR_WIDTH:0] REG_LIMIT = REG_COUNT[REG_ADDR_WIDTH:0];

    logic [XLEN-1:0]      gp_reg [REG_COUNT];
    logic [REG_COUNT-1:0] busy;

    rf_scoreboard #(
        .NUM_WR        (NUM_WR),
        .REG_COUNT     (REG_COUNT),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .areset     (areset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .issue_ready(issue_ready),
        .busy       (busy),
        .busy_count (busy_count)
    );

    // Ports are visited in ascending order so the highest index lands last.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                gp_reg[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && (wr_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0) &&
                    ({1'b0, wr_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]} < REG_LIMIT)) begin
                    gp_reg[wr_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] <= wdata[p*XLEN +: XLEN];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [REG_ADDR_WIDTH-1:0] addr;
            logic                      addr_ok;
            logic [XLEN-1:0]           rdata_k;
            logic                      rbusy_k;

            assign addr    = rd_addr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            assign addr_ok = (addr != '0) && ({1'b0, addr} < REG_LIMIT);

            always_comb begin
                rdata_k = '0;
                rbusy_k = 1'b0;
                if (addr_ok) begin
                    rdata_k = gp_reg[addr];
                    rbusy_k = busy[addr];
                end
`ifdef RF_BYPASS_EN
                for (int p = 0; p < NUM_WR; p++) begin
                    if (!areset && addr_ok && wr_en[p] &&
                        (wr_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr)) begin
                        rdata_k = wdata[p*XLEN +: XLEN];
                        rbusy_k = 1'b0;
                    end
                end
`endif
            end

            assign rdata[gi*XLEN +: XLEN] = rdata_k;
            assign rbusy[gi]              = rbusy_k;
        end
    endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised and directed bench for register_file_mp (3 read ports, 2 write ports)
// against an array-based reference model of the register and busy state.
module tb_register_file_mp;

    localparam int NRD = 3;
    localparam int NWR = 2;

    logic               clk = 1'b0;
    logic               areset = 1'b1;
    logic [NRD*5-1:0]   rd_addr;
    logic [NRD*32-1:0]  rdata;
    logic [NRD-1:0]     rbusy;
    logic [NWR-1:0]     wr_en;
    logic [NWR*5-1:0]   wr_addr;
    logic [NWR*32-1:0]  wdata;
    logic               issue_valid;
    logic [4:0]         issue_addr;
    logic               issue_ready;
    logic [5:0]         busy_count;

    logic [4:0]  ra [NRD];
    logic        we [NWR];
    logic [4:0]  wa [NWR];
    logic [31:0] wd [NWR];
    logic        iv;
    logic [4:0]  ia;

    logic [31:0] model_reg  [32];
    bit          model_busy [32];
    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;

    assign rd_addr     = {ra[2], ra[1], ra[0]};
    assign wr_en       = {we[1], we[0]};
    assign wr_addr     = {wa[1], wa[0]};
    assign wdata       = {wd[1], wd[0]};
    assign issue_valid = iv;
    assign issue_addr  = ia;

    register_file_mp #(.NUM_RD(NRD), .NUM_WR(NWR)) dut (
        .clk        (clk),
        .areset     (areset),
        .rd_addr    (rd_addr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wdata      (wdata),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .issue_ready(issue_ready),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 0) ? 32'h0 : model_reg[a];
`ifdef RF_BYPASS_EN
        for (int p = 0; p < NWR; p++)
            if (we[p] && wa[p] == a && a != 0) v = wd[p];
`endif
        return v;
    endfunction

    function automatic logic exp_rbusy(input logic [4:0] a);
        logic b;
        b = (a == 0) ? 1'b0 : model_busy[a];
`ifdef RF_BYPASS_EN
        for (int p = 0; p < NWR; p++)
            if (we[p] && wa[p] == a && a != 0) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic exp_ready();
        logic r;
        r = (ia == 0) || !model_busy[ia];
        for (int p = 0; p < NWR; p++)
            if (we[p] && wa[p] == ia) r = 1'b1;
        return r;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int r = 0; r < 32; r++) c += model_busy[r] ? 1 : 0;
        return c;
    endfunction

    task automatic idle();
        for (int k = 0; k < NRD; k++) ra[k] = 5'd0;
        for (int p = 0; p < NWR; p++) begin we[p] = 1'b0; wa[p] = 5'd0; wd[p] = 32'h0; end
        iv = 1'b0;
        ia = 5'd0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin model_reg[r] = 32'h0; model_busy[r] = 1'b0; end
    endtask

    // Inputs are already driven (at negedge); check comb outputs, take the edge,
    // advance the model and check the registered count.
    task automatic step();
        logic rdy;
        #1;
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("rdata%0d", k), rdata[k*32 +: 32], exp_rdata(ra[k]));
            check($sformatf("rbusy%0d", k), 32'(rbusy[k]), 32'(exp_rbusy(ra[k])));
        end
        rdy = exp_ready();
        check("issue_ready", 32'(issue_ready), 32'(rdy));
        @(posedge clk);
        #1;
        for (int p = 0; p < NWR; p++)
            if (we[p] && wa[p] != 0) begin model_reg[wa[p]] = wd[p]; model_busy[wa[p]] = 1'b0; end
        if (iv && rdy && ia != 0) model_busy[ia] = 1'b1;
        check("busy_count", 32'(busy_count), 32'(model_count()));
        $display("step %0d: we=%b%b wa=%0d/%0d iv=%b ia=%0d rdy=%b busy_count=%0d",
                 step_no, we[1], we[0], wa[1], wa[0], iv, ia, rdy, busy_count);
        step_no++;
        @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        #1;
        for (int k = 0; k < NRD; k++) begin
            check({tag, "_rdata"}, rdata[k*32 +: 32], 32'h0);
            check({tag, "_rbusy"}, 32'(rbusy[k]), 32'h0);
        end
        check({tag, "_ready"}, 32'(issue_ready), 32'h1);
        check({tag, "_count"}, 32'(busy_count), 32'h0);
    endtask

    initial begin
        idle();
        model_reset();
        ra[0] = 5'd1; ra[1] = 5'd5; ra[2] = 5'd9;
        iv = 1'b1; ia = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_checks("por");
        areset = 1'b0;

        // x0 is hardwired zero
        idle(); we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hDEADBEEF; step();
        idle(); step();

        // issue then writeback
        idle(); iv = 1'b1; ia = 5'd5; step();
        idle(); ra[1] = 5'd5; step();
        idle(); ra[1] = 5'd5; we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'h12345678; step();
        idle(); ra[1] = 5'd5; step();

        // WAW hazard, then same-cycle retire lets the new reservation in
        idle(); iv = 1'b1; ia = 5'd7; step();
        idle(); iv = 1'b1; ia = 5'd7; step();
        idle(); iv = 1'b1; ia = 5'd7; we[1] = 1'b1; wa[1] = 5'd7; wd[1] = 32'h77; step();
        idle(); ra[0] = 5'd7; step();

        // two ports on the same register: highest index wins
        idle(); we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h1;
        we[1] = 1'b1; wa[1] = 5'd3; wd[1] = 32'h2; step();
        idle(); ra[2] = 5'd3; step();

        // bypass case on a busy register
        idle(); we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h1111; step();
        idle(); iv = 1'b1; ia = 5'd9; step();
        idle(); ra[2] = 5'd9; we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'hCAFE; step();
        idle(); ra[2] = 5'd9; step();

        // fill the scoreboard, then retire everything (and over-retire)
        for (int r = 1; r < 32; r++) begin idle(); iv = 1'b1; ia = 5'(r); step(); end
        check("fill_count", 32'(busy_count), 32'd31);
        for (int r = 1; r < 32; r += 2) begin
            idle();
            we[0] = 1'b1; wa[0] = 5'(r); wd[0] = $urandom;
            we[1] = 1'b1; wa[1] = 5'((r + 1) % 32); wd[1] = $urandom;
            step();
        end
        check("drain_count", 32'(busy_count), 32'd0);
        idle(); we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 32'hA5A5A5A5; step();

        // randomised traffic
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < NRD; k++) ra[k] = 5'($urandom_range(0, 31));
            for (int p = 0; p < NWR; p++) begin
                we[p] = ($urandom_range(0, 2) == 0);
                wa[p] = 5'($urandom_range(0, 31));
                wd[p] = $urandom;
            end
            iv = ($urandom_range(0, 1) == 1);
            ia = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) ra[0] = wa[1];
            step();
        end

        // reset in the middle of traffic
        idle(); iv = 1'b1; ia = 5'd12; step();
        idle(); ra[0] = 5'd12; ra[1] = 5'd4; ra[2] = 5'd9;
        iv = 1'b1; ia = 5'd12;
        #2 areset = 1'b1;
        reset_checks("mid");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        idle(); ra[0] = 5'd12; iv = 1'b1; ia = 5'd12; step();
        idle(); ra[0] = 5'd12; we[0] = 1'b1; wa[0] = 5'd12; wd[0] = 32'h0BADF00D; step();
        idle(); ra[0] = 5'd12; step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
